clock_set_ctrl: RTL and testbench
=================================

// Module: clock_set_ctrl
// PURPOSE
//  Key-driven mode controller for the digital clock: sequences time-set and alarm-set editing.
//  Drives set_mod/set_alarm and the edit time hr1/mn1/sd1 into the display mux.
//  Commits edited time to the timekeeper via a load strobe, and owns the alarm registers and alarm match.
//  Sits between the debounced key block and the timekeeper/display mux.
// PARAMETERS
//  TIMEOUT_CYC  32'd0  idle cycles in any edit state before abort to RUN; 0 disables timeout
// PORTS
//  clk        in   1  system clock; all logic on posedge
//  rst        in   1  synchronous, active-high reset
//  key_mode   in   1  1-cycle pulse (debounced): advance field / commit
//  key_alarm  in   1  1-cycle pulse: enter alarm edit (RUN) / abort alarm edit
//  key_inc    in   1  1-cycle pulse: increment selected field
//  key_dec    in   1  1-cycle pulse: decrement selected field
//  hr,mn,sd   in   8  live time, packed BCD {tens,units}
//  set_mod    out  1  1 in any edit state
//  set_alarm  out  1  1 in alarm-edit states
//  hr1,mn1,sd1 out 8  edit value, packed BCD
//  field      out  2  0=none,1=hr,2=mn,3=sd: selected field, for display blink
//  time_load  out  1  1-cycle strobe: load {hr1,mn1,sd1} into timekeeper
//  alarm_hr,alarm_mn out 8  committed alarm, BCD
//  alarm_en   out  1  alarm armed
//  alarm_hit  out  1  alarm_en && state==RUN && hr==alarm_hr && mn==alarm_mn (registered)
// BEHAVIOUR
//  All outputs registered. Key pulse in cycle n -> effect visible in cycle n+1.
//  Reset values: state RUN, all outputs 0; hr1/mn1/sd1/alarm_hr/alarm_mn = 8'h00.
//  States: RUN, T_HR, T_MN, T_SD, A_HR, A_MN.
//   RUN  --key_mode--> T_HR; snapshot hr/mn/sd into hr1/mn1/sd1.
//   RUN  --key_alarm-> A_HR; load hr1<=alarm_hr, mn1<=alarm_mn, sd1<=00.
//   T_HR->T_MN->T_SD on key_mode.
//   T_SD --key_mode--> RUN; time_load=1 for exactly one cycle, set_mod=0 in that same cycle.
//    hr1/mn1/sd1 are stable during the strobe and held afterwards.
//   A_HR->A_MN on key_mode.
//   A_MN --key_mode--> RUN; alarm_hr<=hr1, alarm_mn<=mn1, alarm_en<=1.
//   A_* --key_alarm--> RUN; no commit, alarm_en<=0.
//   key_alarm in T_* states: ignored.
//  Outputs per state:
//   RUN: set_mod=0, set_alarm=0, field=0.
//   T_*: set_mod=1, set_alarm=0.
//   A_*: set_mod=1, set_alarm=1.
//   field = 1/2/3 for hr/mn/sd states.
//  inc/dec on selected field, BCD-correct with wrap:
//   hr 00..23, 23+1->00, 00-1->23; mn/sd 00..59, 59+1->00, 00-1->59.
//   Units 9+1 carries to tens. Never an illegal BCD code.
//  Simultaneous keys, priority mode > alarm > inc > dec; exactly one action per cycle.
//  inc/dec in RUN: ignored.
//  Timeout: counter clears on any key or on entering RUN; increments each cycle in edit states.
//   At TIMEOUT_CYC-1 -> RUN with no commit and no time_load. alarm_en is unchanged.
//  rst mid-edit: immediate return to reset values; pending edit discarded, no time_load.
//  alarm_hit is forced 0 in all edit states.
// STRUCTURE
//  Shared package/header clock_defs: state encoding; BCD limits HR_MAX=8'h23, MS_MAX=8'h59; field codes.
//  Sub-module bcd_field_step:
//   comb; in val[7:0], max[7:0], inc, dec; out next[7:0] with wrap.
//   One instance, fed by muxing the selected field.
//  Top level: FSM, edit regs, alarm regs, timeout counter, match compare.
// TESTING
//  Reset asserted during T_MN -> next cycle state RUN, set_mod=0, hr1=00, time_load never pulses.
//  Time edit, time 12:34:56:
//   key_mode, then inc x12 on hr (12->23->00).
//   Then key_mode x3 -> time_load one cycle with {hr1,mn1,sd1}=00:34:56.
//  Minute wrap: mn1=00, key_dec -> 59; mn1=59, key_inc -> 00; mn1=09, key_inc -> 10.
//  Alarm edit: key_alarm, set 07:30, key_mode x2 -> alarm_hr=07, alarm_mn=30, alarm_en=1.
//   Then hr=07, mn=30 in RUN -> alarm_hit=1 the next cycle.
//  Simultaneous key_mode+key_inc in T_HR -> T_MN, hr1 unchanged.
//   key_inc+key_dec together -> +1.
//  TIMEOUT_CYC=16: enter T_HR, no keys -> cycle 16 back in RUN, time_load=0.
//   A key at cycle 10 extends the timeout to 16 cycles after that key.

Source files
------------

// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the clock set/alarm controller: FSM states, BCD field limits
// and the field-select codes shown to the display blink logic.
package clock_set_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN  = 3'd0,
        ST_T_HR = 3'd1,
        ST_T_MN = 3'd2,
        ST_T_SD = 3'd3,
        ST_A_HR = 3'd4,
        ST_A_MN = 3'd5
    } state_e;

    localparam logic [7:0] HR_MAX = 8'h23;
    localparam logic [7:0] MS_MAX = 8'h59;

    localparam logic [1:0] FLD_NONE = 2'd0;
    localparam logic [1:0] FLD_HR   = 2'd1;
    localparam logic [1:0] FLD_MN   = 2'd2;
    localparam logic [1:0] FLD_SD   = 2'd3;

    function automatic logic [1:0] state_field(state_e s);
        case (s)
            ST_T_HR, ST_A_HR: return FLD_HR;
            ST_T_MN, ST_A_MN: return FLD_MN;
            ST_T_SD:          return FLD_SD;
            default:          return FLD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/clock_set_ctrl_bcd_field_step.sv
// Combinational BCD increment/decrement of one packed {tens,units} field with wrap
// between 00 and max. inc has priority over dec; neither held gives val unchanged.
module bcd_field_step (
    input  logic [7:0] val,
    input  logic [7:0] max,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] next
);

    logic [3:0] tens;
    logic [3:0] units;

    assign tens  = val[7:4];
    assign units = val[3:0];

    always_comb begin
        next = val;
        if (inc) begin
            if (val == max)          next = 8'h00;
            else if (units == 4'd9)  next = {tens + 4'd1, 4'd0};
            else                     next = {tens, units + 4'd1};
        end else if (dec) begin
            if (val == 8'h00)        next = max;
            else if (units == 4'd0)  next = {tens - 4'd1, 4'd9};
            else                     next = {tens, units - 4'd1};
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Key-driven time-set / alarm-set controller: edits hr1/mn1/sd1, strobes time_load on
// commit, owns the alarm registers and the registered alarm match.
module clock_set_ctrl
    import clock_set_ctrl_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYC = 32'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_alarm,
    input  logic       key_inc,
    input  logic       key_dec,
    input  logic [7:0] hr,
    input  logic [7:0] mn,
    input  logic [7:0] sd,
    output logic       set_mod,
    output logic       set_alarm,
    output logic [7:0] hr1,
    output logic [7:0] mn1,
    output logic [7:0] sd1,
    output logic [1:0] field,
    output logic       time_load,
    output logic [7:0] alarm_hr,
    output logic [7:0] alarm_mn,
    output logic       alarm_en,
    output logic       alarm_hit
);

    state_e      state_q, state_d;
    logic [7:0]  hr1_q, hr1_d, mn1_q, mn1_d, sd1_q, sd1_d;
    logic [7:0]  alarm_hr_q, alarm_hr_d, alarm_mn_q, alarm_mn_d;
    logic        alarm_en_q, alarm_en_d, alarm_hit_q, alarm_hit_d;
    logic        time_load_q, time_load_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  step_val, step_max, step_next;
    logic        key_any;

    assign key_any = key_mode | key_alarm | key_inc | key_dec;

    // Only the field belonging to the current state is fed to the single stepper
    always_comb begin
        step_val = hr1_q;
        step_max = HR_MAX;
        case (state_q)
            ST_T_MN, ST_A_MN: begin step_val = mn1_q; step_max = MS_MAX; end
            ST_T_SD:          begin step_val = sd1_q; step_max = MS_MAX; end
            default: ;
        endcase
    end

    bcd_field_step u_step (
        .val  (step_val),
        .max  (step_max),
        .inc  (key_inc),
        .dec  (key_dec),
        .next (step_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            hr1_q       <= 8'h00;
            mn1_q       <= 8'h00;
            sd1_q       <= 8'h00;
            alarm_hr_q  <= 8'h00;
            alarm_mn_q  <= 8'h00;
            alarm_en_q  <= 1'b0;
            alarm_hit_q <= 1'b0;
            time_load_q <= 1'b0;
            cnt_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            hr1_q       <= hr1_d;
            mn1_q       <= mn1_d;
            sd1_q       <= sd1_d;
            alarm_hr_q  <= alarm_hr_d;
            alarm_mn_q  <= alarm_mn_d;
            alarm_en_q  <= alarm_en_d;
            alarm_hit_q <= alarm_hit_d;
            time_load_q <= time_load_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hr1_d       = hr1_q;
        mn1_d       = mn1_q;
        sd1_d       = sd1_q;
        alarm_hr_d  = alarm_hr_q;
        alarm_mn_d  = alarm_mn_q;
        alarm_en_d  = alarm_en_q;
        time_load_d = 1'b0;
        cnt_d       = 32'd0;
        if (state_q == ST_RUN) begin
            if (key_mode) begin
                state_d = ST_T_HR;
                hr1_d   = hr;
                mn1_d   = mn;
                sd1_d   = sd;
            end else if (key_alarm) begin
                state_d = ST_A_HR;
                hr1_d   = alarm_hr_q;
                mn1_d   = alarm_mn_q;
                sd1_d   = 8'h00;
            end
        end else begin
            if (key_mode) begin
                case (state_q)
                    ST_T_HR: state_d = ST_T_MN;
                    ST_T_MN: state_d = ST_T_SD;
                    ST_A_HR: state_d = ST_A_MN;
                    ST_T_SD: begin
                        state_d     = ST_RUN;
                        time_load_d = 1'b1;
                    end
                    default: begin
                        state_d    = ST_RUN;
                        alarm_hr_d = hr1_q;
                        alarm_mn_d = mn1_q;
                        alarm_en_d = 1'b1;
                    end
                endcase
            end else if (key_alarm && (state_q == ST_A_HR || state_q == ST_A_MN)) begin
                state_d    = ST_RUN;
                alarm_en_d = 1'b0;
            end else if (key_inc || key_dec) begin
                case (state_q)
                    ST_T_MN, ST_A_MN: mn1_d = step_next;
                    ST_T_SD:          sd1_d = step_next;
                    default:          hr1_d = step_next;
                endcase
            end
            // Idle abort leaves the edit registers and alarm_en untouched
            if (!key_any) begin
                if (TIMEOUT_CYC != 32'd0 && cnt_q == TIMEOUT_CYC - 32'd1) state_d = ST_RUN;
                else cnt_d = cnt_q + 32'd1;
            end
        end
        alarm_hit_d = alarm_en_q && (state_d == ST_RUN) &&
                      (hr == alarm_hr_q) && (mn == alarm_mn_q);
    end

    always_comb begin
        set_mod   = (state_q != ST_RUN);
        set_alarm = (state_q == ST_A_HR) || (state_q == ST_A_MN);
        field     = state_field(state_q);
    end

    assign hr1       = hr1_q;
    assign mn1       = mn1_q;
    assign sd1       = sd1_q;
    assign time_load = time_load_q;
    assign alarm_hr  = alarm_hr_q;
    assign alarm_mn  = alarm_mn_q;
    assign alarm_en  = alarm_en_q;
    assign alarm_hit = alarm_hit_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: table vectors, hand-written corner sequences and a random run,
// every cycle also compared against an integer-arithmetic reference model.
module tb_clock_set_ctrl;

    localparam int TO = 16;
    localparam logic [3:0] K_NONE  = 4'b0000;
    localparam logic [3:0] K_MODE  = 4'b1000;
    localparam logic [3:0] K_ALARM = 4'b0100;
    localparam logic [3:0] K_INC   = 4'b0010;
    localparam logic [3:0] K_DEC   = 4'b0001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_mode = 1'b0, key_alarm = 1'b0, key_inc = 1'b0, key_dec = 1'b0;
    logic [7:0] hr = 8'h00, mn = 8'h00, sd = 8'h00;
    logic       set_mod, set_alarm, time_load, alarm_en, alarm_hit;
    logic [7:0] hr1, mn1, sd1, alarm_hr, alarm_mn;
    logic [1:0] field;

    clock_set_ctrl #(.TIMEOUT_CYC(32'd16)) dut (
        .clk(clk), .rst(rst),
        .key_mode(key_mode), .key_alarm(key_alarm), .key_inc(key_inc), .key_dec(key_dec),
        .hr(hr), .mn(mn), .sd(sd),
        .set_mod(set_mod), .set_alarm(set_alarm),
        .hr1(hr1), .mn1(mn1), .sd1(sd1), .field(field), .time_load(time_load),
        .alarm_hr(alarm_hr), .alarm_mn(alarm_mn), .alarm_en(alarm_en), .alarm_hit(alarm_hit)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    // Reference model: edit kind (0 none, 1 time, 2 alarm), field index, plain integers
    int m_edit = 0, m_fld = 0, e_h = 0, e_m = 0, e_s = 0, a_h = 0, a_m = 0, idle = 0;
    bit m_en = 0, m_ld = 0, m_hit = 0;

    task automatic model_update(input bit r, input logic [3:0] k, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        bit old_match;
        int lim, delta;
        old_match = m_en && (a_h == from_bcd(h)) && (a_m == from_bcd(m));
        m_ld = 0;
        if (r) begin
            m_edit = 0; m_fld = 0; e_h = 0; e_m = 0; e_s = 0;
            a_h = 0; a_m = 0; idle = 0; m_en = 0; m_hit = 0;
            return;
        end
        if (m_edit == 0) begin
            if (k[3]) begin
                m_edit = 1; m_fld = 1; e_h = from_bcd(h); e_m = from_bcd(m); e_s = from_bcd(s);
            end else if (k[2]) begin
                m_edit = 2; m_fld = 1; e_h = a_h; e_m = a_m; e_s = 0;
            end
            idle = 0;
        end else begin
            if (k[3]) begin
                if (m_fld < ((m_edit == 1) ? 3 : 2)) m_fld++;
                else begin
                    if (m_edit == 1) m_ld = 1;
                    else begin a_h = e_h; a_m = e_m; m_en = 1; end
                    m_edit = 0;
                end
            end else if (k[2] && m_edit == 2) begin
                m_edit = 0; m_en = 0;
            end else if (k[1] || k[0]) begin
                lim = (m_fld == 1) ? 24 : 60;
                delta = k[1] ? 1 : lim - 1;
                if (m_fld == 1) e_h = (e_h + delta) % lim;
                else if (m_fld == 2) e_m = (e_m + delta) % lim;
                else e_s = (e_s + delta) % lim;
            end
            if (k != 4'b0000) idle = 0;
            else if (idle == TO - 1) begin m_edit = 0; idle = 0; end
            else idle++;
        end
        m_hit = old_match && (m_edit == 0);
    endtask

    function automatic logic [46:0] model_vec();
        logic [1:0] f;
        f = (m_edit != 0) ? 2'(m_fld) : 2'd0;
        return {m_edit != 0, m_edit == 2, f, m_ld, m_en, m_hit,
                to_bcd(e_h), to_bcd(e_m), to_bcd(e_s), to_bcd(a_h), to_bcd(a_m)};
    endfunction

    logic [46:0] dut_vec;
    assign dut_vec = {set_mod, set_alarm, field, time_load, alarm_en, alarm_hit,
                      hr1, mn1, sd1, alarm_hr, alarm_mn};

    // One clock cycle: drive at negedge, model on posedge, compare at the next negedge
    task automatic step(input bit r, input logic [3:0] k, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        rst = r;
        {key_mode, key_alarm, key_inc, key_dec} = k;
        hr = h; mn = m; sd = s;
        @(posedge clk);
        model_update(r, k, h, m, s);
        @(negedge clk);
        rst = 1'b0;
        {key_mode, key_alarm, key_inc, key_dec} = K_NONE;
        chk("model", {17'd0, dut_vec}, {17'd0, model_vec()});
    endtask

    typedef struct {
        logic [3:0] keys;
        logic       sm;
        logic [1:0] fld;
        logic [7:0] h1, m1, s1;
        logic       ld;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t row(input logic [3:0] k, input logic [7:0] h1, input logic [7:0] m1,
                                 input logic [7:0] s1, input logic sm, input logic [1:0] f, input logic ld);
        vec_t v;
        v.keys = k; v.h1 = h1; v.m1 = m1; v.s1 = s1; v.sm = sm; v.fld = f; v.ld = ld;
        return v;
    endfunction

    task automatic run_table(input string tag, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        foreach (tv[i]) begin
            step(1'b0, tv[i].keys, h, m, s);
            chk($sformatf("%s_row%0d", tag, i), {36'd0, set_mod, field, hr1, mn1, sd1, time_load},
                {36'd0, tv[i].sm, tv[i].fld, tv[i].h1, tv[i].m1, tv[i].s1, tv[i].ld});
        end
        tv.delete();
    endtask

    initial begin
        logic [3:0] k;
        logic [7:0] rh, rm, rs;

        step(1'b1, K_NONE, 8'h12, 8'h34, 8'h56);
        chk("reset_state", {17'd0, dut_vec}, 64'd0);

        // Time edit 12:34:56: hr 12 -> 23 -> 00, commit 00:34:56
        tv.push_back(row(K_MODE, 8'h12, 8'h34, 8'h56, 1, 1, 0));
        for (int i = 1; i <= 12; i++) tv.push_back(row(K_INC, to_bcd((12 + i) % 24), 8'h34, 8'h56, 1, 1, 0));
        tv.push_back(row(K_MODE, 8'h00, 8'h34, 8'h56, 1, 2, 0));
        tv.push_back(row(K_MODE, 8'h00, 8'h34, 8'h56, 1, 3, 0));
        tv.push_back(row(K_MODE, 8'h00, 8'h34, 8'h56, 0, 0, 1));
        tv.push_back(row(K_NONE, 8'h00, 8'h34, 8'h56, 0, 0, 0));
        run_table("time", 8'h12, 8'h34, 8'h56);

        // Minute/second wrap, key_alarm ignored in a time-edit state
        tv.push_back(row(K_MODE,  8'h10, 8'h00, 8'h09, 1, 1, 0));
        tv.push_back(row(K_MODE,  8'h10, 8'h00, 8'h09, 1, 2, 0));
        tv.push_back(row(K_DEC,   8'h10, 8'h59, 8'h09, 1, 2, 0));
        tv.push_back(row(K_INC,   8'h10, 8'h00, 8'h09, 1, 2, 0));
        tv.push_back(row(K_MODE,  8'h10, 8'h00, 8'h09, 1, 3, 0));
        tv.push_back(row(K_INC,   8'h10, 8'h00, 8'h10, 1, 3, 0));
        tv.push_back(row(K_DEC,   8'h10, 8'h00, 8'h09, 1, 3, 0));
        tv.push_back(row(K_ALARM, 8'h10, 8'h00, 8'h09, 1, 3, 0));
        tv.push_back(row(K_MODE,  8'h10, 8'h00, 8'h09, 0, 0, 1));
        run_table("minwrap", 8'h10, 8'h00, 8'h09);

        tv.push_back(row(K_MODE, 8'h05, 8'h09, 8'h00, 1, 1, 0));
        tv.push_back(row(K_DEC,  8'h04, 8'h09, 8'h00, 1, 1, 0));
        tv.push_back(row(K_MODE, 8'h04, 8'h09, 8'h00, 1, 2, 0));
        tv.push_back(row(K_INC,  8'h04, 8'h10, 8'h00, 1, 2, 0));
        tv.push_back(row(K_MODE, 8'h04, 8'h10, 8'h00, 1, 3, 0));
        tv.push_back(row(K_MODE, 8'h04, 8'h10, 8'h00, 0, 0, 1));
        run_table("carry", 8'h05, 8'h09, 8'h00);

        // Alarm edit to 07:30, then a live match
        step(1'b0, K_ALARM, 8'h01, 8'h02, 8'h03);
        chk("alarm_enter", {set_mod, set_alarm, field, hr1, sd1}, {1'b1, 1'b1, 2'd1, 8'h00, 8'h00});
        step(1'b0, K_DEC, 8'h01, 8'h02, 8'h03);
        chk("hr_dec_wrap", hr1, 8'h23);
        step(1'b0, K_INC, 8'h01, 8'h02, 8'h03);
        chk("hr_inc_wrap", hr1, 8'h00);
        for (int i = 0; i < 7; i++) step(1'b0, K_INC, 8'h01, 8'h02, 8'h03);
        step(1'b0, K_MODE, 8'h01, 8'h02, 8'h03);
        for (int i = 0; i < 30; i++) step(1'b0, K_INC, 8'h01, 8'h02, 8'h03);
        step(1'b0, K_MODE, 8'h01, 8'h02, 8'h03);
        chk("alarm_commit", {set_mod, alarm_hr, alarm_mn, alarm_en}, {1'b0, 8'h07, 8'h30, 1'b1});
        step(1'b0, K_NONE, 8'h07, 8'h30, 8'h00);
        chk("alarm_hit", alarm_hit, 1);
        step(1'b0, K_ALARM, 8'h07, 8'h30, 8'h00);
        chk("hit_off_in_edit", {alarm_hit, set_alarm}, {1'b0, 1'b1});
        step(1'b0, K_ALARM, 8'h07, 8'h30, 8'h00);
        chk("alarm_abort", {set_mod, alarm_en, alarm_hr, alarm_mn}, {1'b0, 1'b0, 8'h07, 8'h30});

        // Simultaneous keys
        step(1'b0, K_MODE, 8'h12, 8'h34, 8'h56);
        step(1'b0, K_MODE | K_INC, 8'h12, 8'h34, 8'h56);
        chk("mode_beats_inc", {field, hr1}, {2'd2, 8'h12});
        step(1'b0, K_INC | K_DEC, 8'h12, 8'h34, 8'h56);
        chk("inc_beats_dec", mn1, 8'h35);
        step(1'b0, K_MODE, 8'h12, 8'h34, 8'h56);
        step(1'b0, K_MODE, 8'h12, 8'h34, 8'h56);
        chk("simul_commit", {time_load, hr1, mn1, sd1}, {1'b1, 8'h12, 8'h35, 8'h56});

        // Idle timeout: 16 cycles in edit, then RUN with no load
        step(1'b0, K_MODE, 8'h12, 8'h34, 8'h56);
        for (int i = 1; i < TO; i++) begin
            step(1'b0, K_NONE, 8'h12, 8'h34, 8'h56);
            chk($sformatf("to_hold%0d", i), set_mod, 1);
        end
        step(1'b0, K_NONE, 8'h12, 8'h34, 8'h56);
        chk("to_expire", {set_mod, time_load}, {1'b0, 1'b0});

        step(1'b0, K_MODE, 8'h12, 8'h34, 8'h56);
        for (int i = 1; i < 10; i++) step(1'b0, K_NONE, 8'h12, 8'h34, 8'h56);
        step(1'b0, K_INC, 8'h12, 8'h34, 8'h56);
        for (int i = 1; i < TO; i++) step(1'b0, K_NONE, 8'h12, 8'h34, 8'h56);
        chk("to_extended", {set_mod, hr1}, {1'b1, 8'h13});
        step(1'b0, K_NONE, 8'h12, 8'h34, 8'h56);
        chk("to_ext_expire", {set_mod, time_load}, {1'b0, 1'b0});

        // Reset during T_MN
        step(1'b0, K_MODE, 8'h12, 8'h34, 8'h56);
        step(1'b0, K_MODE, 8'h12, 8'h34, 8'h56);
        step(1'b1, K_MODE | K_INC, 8'h12, 8'h34, 8'h56);
        chk("rst_mid_edit", {set_mod, field, hr1, time_load}, {1'b0, 2'd0, 8'h00, 1'b0});
        for (int i = 0; i < 3; i++) begin
            step(1'b0, K_NONE, 8'h12, 8'h34, 8'h56);
            chk($sformatf("rst_no_load%0d", i), time_load, 0);
        end

        // Random run against the model
        for (int n = 0; n < 3000; n++) begin
            k[3] = ($urandom_range(0, 5) == 0);
            k[2] = ($urandom_range(0, 9) == 0);
            k[1] = ($urandom_range(0, 3) == 0);
            k[0] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) begin
                rh = to_bcd(a_h); rm = to_bcd(a_m);
            end else begin
                rh = to_bcd(int'($urandom_range(0, 23))); rm = to_bcd(int'($urandom_range(0, 59)));
            end
            rs = to_bcd(int'($urandom_range(0, 59)));
            step($urandom_range(0, 199) == 0, k, rh, rm, rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
